// File: rtl/riscv_load_store_unit.sv
// riscv_load_store_unit
// Data-memory load/store unit beside the execute stage. Computes the access
// address, checks alignment, forms byte enables and lane-shifted store data,
// and drives a single-outstanding req/gnt/rvalid bus. Load responses are
// aligned and extended using the attributes latched when the access was
// granted, so a new access can be granted in the same cycle as the previous
// response without disturbing it.

module riscv_load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_req_ex_i,
  input  logic                  data_we_ex_i,
  input  logic [1:0]            data_type_ex_i,
  input  logic                  data_sign_ext_ex_i,
  input  logic [31:0]           data_operand_a_ex_i,
  input  logic [31:0]           data_operand_b_ex_i,
  input  logic [31:0]           data_wdata_ex_i,
  input  logic                  ex_valid_i,
  output logic                  lsu_ready_ex_o,
  output logic                  lsu_ready_wb_o,
  output logic                  data_misaligned_o,
  output logic [31:0]           data_rdata_ex_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [31:0]           data_wdata_o,
  input  logic [31:0]           data_rdata_i
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } lsu_state_e;

  lsu_state_e  state_r;
  lsu_state_e  state_nxt_s;
  lsu_state_e  issue_state_s;

  logic        issued_r;
  logic [1:0]  data_type_r;
  logic        sign_ext_r;
  logic [1:0]  off_r;
  logic        we_r;

  logic [31:0] addr_s;
  logic [1:0]  off_s;
  logic        misaligned_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_rot_s;
  logic        state_allows_req_s;
  logic        req_s;
  logic        grant_s;
  logic        ready_ex_s;
  logic        ready_wb_s;
  logic [31:0] rdata_shift_s;
  logic [31:0] rdata_ext_s;
  logic [31:0] rdata_out_s;

  // Effective address: the sum wraps modulo 2^32, the low two bits select the lane
  always_comb begin
    addr_s = data_operand_a_ex_i + data_operand_b_ex_i;
    off_s  = addr_s[1:0];
  end

  // Alignment check; only meaningful when EX actually holds a memory access
  always_comb begin
    misaligned_s = 1'b0;
    if (data_req_ex_i) begin
      case (data_type_ex_i)
        2'b01:   misaligned_s = off_s[0];
        2'b10:   misaligned_s = 1'b0;
        default: misaligned_s = (off_s != 2'b00);
      endcase
    end else begin
      misaligned_s = 1'b0;
    end
  end

  // Byte enables for the addressed lanes
  always_comb begin
    be_s = 4'b1111;
    case (data_type_ex_i)
      2'b01:   be_s = off_s[1] ? 4'b1100 : 4'b0011;
      2'b10:   be_s = 4'b0001 << off_s;
      default: be_s = 4'b1111;
    endcase
  end

  // Store data rotated so the LSB-justified value lands on the addressed lanes
  always_comb begin
    wdata_rot_s = data_wdata_ex_i;
    case (off_s)
      2'b01:   wdata_rot_s = {data_wdata_ex_i[23:0], data_wdata_ex_i[31:24]};
      2'b10:   wdata_rot_s = {data_wdata_ex_i[15:0], data_wdata_ex_i[31:16]};
      2'b11:   wdata_rot_s = {data_wdata_ex_i[7:0],  data_wdata_ex_i[31:8]};
      default: wdata_rot_s = data_wdata_ex_i;
    endcase
  end

  // A new request may go out when idle, while waiting for grant, or in the
  // cycle the outstanding response returns (keeps one transaction in flight)
  always_comb begin
    state_allows_req_s = 1'b0;
    case (state_r)
      IDLE:        state_allows_req_s = 1'b1;
      WAIT_GNT:    state_allows_req_s = 1'b1;
      WAIT_RVALID: state_allows_req_s = data_rvalid_i;
      default:     state_allows_req_s = 1'b0;
    endcase
    req_s         = data_req_ex_i & ~misaligned_s & ~issued_r & state_allows_req_s;
    grant_s       = req_s & data_gnt_i;
    issue_state_s = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
  end

  // Next-state logic for the bus handshake
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          state_nxt_s = issue_state_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT_GNT: begin
        if (req_s) begin
          state_nxt_s = issue_state_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT_RVALID: begin
        if (data_rvalid_i) begin
          if (req_s) begin
            state_nxt_s = issue_state_s;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = WAIT_RVALID;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Handshake state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Issued flag: stops the same EX instruction re-requesting while EX is
  // held by some other unit after its access was already granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_r <= 1'b0;
    end else if (ex_valid_i) begin
      issued_r <= 1'b0;
    end else if (grant_s) begin
      issued_r <= 1'b1;
    end
  end

  // Access attributes captured at grant; they steer the matching response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_type_r <= 2'b00;
      sign_ext_r  <= 1'b0;
      off_r       <= 2'b00;
      we_r        <= 1'b0;
    end else if (grant_s) begin
      data_type_r <= data_type_ex_i;
      sign_ext_r  <= data_sign_ext_ex_i;
      off_r       <= off_s;
      we_r        <= data_we_ex_i;
    end
  end

  // EX ready: stall while a request is unanswered by grant, or while a new
  // access waits behind an outstanding response
  always_comb begin
    ready_ex_s = 1'b1;
    if (req_s && !data_gnt_i) begin
      ready_ex_s = 1'b0;
    end else if ((state_r == WAIT_RVALID) && data_req_ex_i && !misaligned_s &&
                 !issued_r && !data_rvalid_i) begin
      ready_ex_s = 1'b0;
    end else begin
      ready_ex_s = 1'b1;
    end
  end

  // WB ready: low only while a response is still outstanding
  always_comb begin
    ready_wb_s = 1'b1;
    if (state_r == WAIT_RVALID) begin
      ready_wb_s = data_rvalid_i;
    end else begin
      ready_wb_s = 1'b1;
    end
  end

  // Load alignment and extension using the latched attributes
  always_comb begin
    rdata_shift_s = data_rdata_i >> {off_r, 3'b000};
    rdata_ext_s   = rdata_shift_s;
    case (data_type_r)
      2'b10: begin
        if (sign_ext_r) begin
          rdata_ext_s = {{24{rdata_shift_s[7]}}, rdata_shift_s[7:0]};
        end else begin
          rdata_ext_s = {24'h000000, rdata_shift_s[7:0]};
        end
      end
      2'b01: begin
        if (sign_ext_r) begin
          rdata_ext_s = {{16{rdata_shift_s[15]}}, rdata_shift_s[15:0]};
        end else begin
          rdata_ext_s = {16'h0000, rdata_shift_s[15:0]};
        end
      end
      default: rdata_ext_s = rdata_shift_s;
    endcase
  end

  // Load result is driven only for a real load response, zero otherwise
  always_comb begin
    rdata_out_s = 32'h0000_0000;
    if ((state_r == WAIT_RVALID) && data_rvalid_i && !we_r) begin
      rdata_out_s = rdata_ext_s;
    end else begin
      rdata_out_s = 32'h0000_0000;
    end
  end

  assign data_req_o        = req_s;
  assign data_addr_o       = {addr_s[ADDR_WIDTH-1:2], 2'b00};
  assign data_we_o         = data_we_ex_i;
  assign data_be_o         = be_s;
  assign data_wdata_o      = wdata_rot_s;
  assign data_misaligned_o = misaligned_s;
  assign lsu_ready_ex_o    = ready_ex_s;
  assign lsu_ready_wb_o    = ready_wb_s;
  assign data_rdata_ex_o   = rdata_out_s;

  riscv_load_store_unit_chk u_chk (
    .clk               (clk),
    .rst_n             (rst_n),
    .data_req_o        (data_req_o),
    .data_gnt_i        (data_gnt_i),
    .data_misaligned_o (data_misaligned_o),
    .lsu_ready_ex_o    (lsu_ready_ex_o)
  );

endmodule

// Protocol checker for the LSU bus side
module riscv_load_store_unit_chk (
  input logic clk,
  input logic rst_n,
  input logic data_req_o,
  input logic data_gnt_i,
  input logic data_misaligned_o,
  input logic lsu_ready_ex_o
);

  // A misaligned access must never reach the bus
  a_no_misaligned_req: assert property (@(posedge clk) disable iff (!rst_n)
    !(data_req_o && data_misaligned_o));

  // An ungranted request must stall EX
  a_stall_until_gnt: assert property (@(posedge clk) disable iff (!rst_n)
    (data_req_o && !data_gnt_i) |-> !lsu_ready_ex_o);

endmodule
